// File: rtl/serv_alu_core_pkg.sv
// Shared constants for the bit-serial ALU: opcode codes, cycle-vector bit
// positions and the operand width.
package serv_alu_core_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00101;
   localparam logic [4:0] OP_SUB = 5'b01010;
   localparam logic [4:0] OP_XOR = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00001;
   localparam logic [4:0] OP_LT  = 5'b10000;
   localparam logic [4:0] OP_EQ  = 5'b01000;

   localparam int CYC_FIRST = 5;
   localparam int CYC_LAST  = 6;
   localparam int CYC_RUN   = 7;

   // Unknown codes collapse to NOP so the datapath only ever sees legal ops.
   function automatic logic [4:0] decode_op(input logic [4:0] code);
      case (code)
         OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_LT, OP_EQ: return code;
         default: return OP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/serv_alu_core_cycler.sv
// Free-running 32-step cycle generator: bit index plus first/last/running flags.
// The cycle after reset release is a startup step; index 0 follows it.
module serv_alu_core_cycler
   import serv_alu_core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] cycle
);

   logic [4:0] nxt;

   always_comb begin
      nxt = cycle[CYC_RUN] ? cycle[4:0] + 5'd1 : 5'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle <= 8'd0;
      end else begin
         cycle[4:0]       <= nxt;
         cycle[CYC_FIRST] <= (nxt == 5'd0);
         cycle[CYC_LAST]  <= (nxt == 5'd31);
         cycle[CYC_RUN]   <= 1'b1;
      end
   end

endmodule

// File: rtl/serv_alu_core.sv
// Bit-serial 32-bit ALU: one operand bit pair in, one result bit out per clock,
// with op latching at index 0 and a deserializer producing the full word.
module serv_alu_core
   import serv_alu_core_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            A,
   input  logic            B,
   input  logic [5:0]      inst,
   output logic            o_valid,
   output logic            o_rd,
   output logic            o_cmp,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic [7:0]      cycle
);

   logic            run, first, last, valid;
   logic [4:0]      op, op_q;
   logic            sgn, sgn_q;
   logic            carry, eq_q;
   logic            b_eff, cin, sum, cout, eq_nxt, lt_bit, sub_mode;
   logic [XLEN-1:0] shreg;

   serv_alu_core_cycler u_cycler (
      .clk   (clk),
      .reset (reset),
      .cycle (cycle)
   );

   assign run   = cycle[CYC_RUN];
   assign first = run & cycle[CYC_FIRST];
   assign last  = run & cycle[CYC_LAST];

   // Index 0 sees inst directly so the op takes effect without a cycle of delay.
   always_comb begin
      op  = op_q;
      sgn = sgn_q;
      if (first) begin
         op  = decode_op(inst[4:0]);
         sgn = inst[5];
      end
   end

   assign valid   = run & (op != OP_NOP);
   assign o_valid = valid;

   always_comb begin
      sub_mode = (op == OP_SUB) || (op == OP_LT);
      b_eff    = sub_mode ? ~B : B;
      cin      = first ? sub_mode : carry;
      sum      = A ^ b_eff ^ cin;
      cout     = (A & b_eff) | (cin & (A ^ b_eff));
      eq_nxt   = (first ? 1'b1 : eq_q) & ~(A ^ B);
      // Signed compare only consults the borrow when the sign bits agree.
      lt_bit   = (sgn && (A != B)) ? A : ~cout;
      o_rd     = 1'b0;
      if (valid) begin
         case (op)
            OP_ADD, OP_SUB: o_rd = sum;
            OP_XOR:         o_rd = A ^ B;
            OP_AND:         o_rd = A & B;
            OP_OR:          o_rd = A | B;
            default:        o_rd = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q         <= OP_NOP;
         sgn_q        <= 1'b0;
         carry        <= 1'b0;
         eq_q         <= 1'b1;
         shreg        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         o_cmp        <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (first) begin
            op_q  <= op;
            sgn_q <= sgn;
         end
         if (valid) begin
            carry <= cout;
            eq_q  <= eq_nxt;
            shreg <= {o_rd, shreg[XLEN-1:1]};
            if (last) begin
               result       <= {o_rd, shreg[XLEN-1:1]};
               result_valid <= 1'b1;
               o_cmp        <= (op == OP_EQ) ? eq_nxt :
                               (op == OP_LT) ? lt_bit : 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_serv_alu_core.sv
// Scoreboard bench for serv_alu_core: directed vectors plus a small sweep
// checked against arithmetic expectations.
module tb_serv_alu_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        A = 1'b0;
   logic        B = 1'b0;
   logic [5:0]  inst = 6'd0;
   logic        o_valid, o_rd, o_cmp, result_valid;
   logic [31:0] result;
   logic [7:0]  cycle;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] res;
      logic        cmp;
      logic        chk_cmp;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   serv_alu_core dut (
      .clk          (clk),
      .reset        (reset),
      .A            (A),
      .B            (B),
      .inst         (inst),
      .o_valid      (o_valid),
      .o_rd         (o_rd),
      .o_cmp        (o_cmp),
      .result       (result),
      .result_valid (result_valid),
      .cycle        (cycle)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   function automatic exp_t model(input logic [5:0] in, input logic [31:0] a,
                                  input logic [31:0] b, input string nm);
      exp_t e;
      e.res = 32'd0; e.cmp = 1'b0; e.chk_cmp = 1'b0; e.name = nm;
      case (in[4:0])
         5'b00101: e.res = a + b;
         5'b01010: e.res = a - b;
         5'b00100: e.res = a ^ b;
         5'b00010: e.res = a & b;
         5'b00001: e.res = a | b;
         5'b10000: begin
            e.chk_cmp = 1'b1;
            e.cmp = in[5] ? ($signed(a) < $signed(b)) : (a < b);
         end
         5'b01000: begin
            e.chk_cmp = 1'b1;
            e.cmp = (a == b);
         end
         default: e.res = 32'd0;
      endcase
      return e;
   endfunction

   task automatic wait_window_start();
      int n = 0;
      while (!(cycle[7] && cycle[4:0] == 5'd0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++;
         fails++;
         $display("FAIL window_start: timed out after %0d cycles, required index 0", n);
      end
   endtask

   // Drives one 32-cycle window; inst is scrambled after index 0 to prove latching.
   task automatic drive(input logic [5:0] in, input logic [31:0] a, input logic [31:0] b,
                        input int nbits);
      wait_window_start();
      for (int i = 0; i < nbits; i++) begin
         inst = (i == 0) ? in : 6'($urandom);
         A = a[i];
         B = b[i];
         @(negedge clk);
      end
   endtask

   task automatic issue(input logic [5:0] in, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic cmp, input logic chk,
                        input string nm);
      exp_t e;
      e.res = res; e.cmp = cmp; e.chk_cmp = chk; e.name = nm;
      exp_q.push_back(e);
      drive(in, a, b, 32);
   endtask

   task automatic issue_model(input logic [5:0] in, input logic [31:0] a, input logic [31:0] b);
      exp_q.push_back(model(in, a, b, $sformatf("sweep op=%b a=%0d b=%0d", in, a, b)));
      drive(in, a, b, 32);
   endtask

   // Monitor: every result_valid pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && result_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result_valid: got result %h with no operation pending", result);
            end else begin
               e = exp_q.pop_front();
               check({e.name, " result"}, result, e.res);
               if (e.chk_cmp) check({e.name, " o_cmp"}, {31'd0, o_cmp}, {31'd0, e.cmp});
               check({e.name, " pulse index"}, {27'd0, cycle[4:0]}, 32'd0);
            end
         end
      end
   end

   logic [31:0] vals [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd127, 32'd128, 32'd200, 32'd255};
   logic [5:0]  ops  [8] = '{6'b100101, 6'b001010, 6'b000100, 6'b000010,
                             6'b000001, 6'b010000, 6'b110000, 6'b001000};

   initial begin
      logic [4:0] idx;
      int n;

      repeat (3) @(negedge clk);
      check("reset cycle", {24'd0, cycle}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset result_valid", {31'd0, result_valid}, 32'd0);
      check("reset o_valid", {31'd0, o_valid}, 32'd0);
      check("reset o_cmp", {31'd0, o_cmp}, 32'd0);
      check("reset o_rd", {31'd0, o_rd}, 32'd0);

      reset = 1'b0;
      n = 0;
      while (!cycle[7] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("run after release", {31'd0, cycle[7]}, 32'd1);
      idx = 5'd0;
      for (int i = 0; i < 64; i++) begin
         check("nop cycle vector", {24'd0, cycle},
               {24'd0, 1'b1, idx == 5'd31, idx == 5'd0, idx});
         check("nop o_valid", {31'd0, o_valid}, 32'd0);
         check("nop result_valid", {31'd0, result_valid}, 32'd0);
         idx = idx + 5'd1;
         @(negedge clk);
      end

      issue(6'b100101, 32'd255, 32'd255, 32'd510, 1'b0, 1'b0, "add 255+255");
      issue(6'b100101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, "add wrap");
      issue(6'b001010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub 5-7");
      issue(6'b001010, 32'd200, 32'd56, 32'd144, 1'b0, 1'b0, "sub 200-56");
      issue(6'b000100, 32'hF0, 32'h3C, 32'hCC, 1'b0, 1'b0, "xor");
      issue(6'b000010, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, "and");
      issue(6'b000001, 32'hF0, 32'h3C, 32'hFC, 1'b0, 1'b0, "or");
      issue(6'b010000, 32'd3, 32'd200, 32'd0, 1'b1, 1'b1, "ltu 3<200");
      issue(6'b010000, 32'd200, 32'd3, 32'd0, 1'b0, 1'b1, "ltu 200<3");
      issue(6'b110000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, "lts -1<1");
      issue(6'b010000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, "ltu max<1");
      issue(6'b110000, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, "lts 5<5");
      issue(6'b001000, 32'h5A, 32'h5A, 32'd0, 1'b1, 1'b1, "eq same");
      issue(6'b001000, 32'h5A, 32'h5B, 32'd0, 1'b0, 1'b1, "eq differ");
      issue(6'b101000, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1, "eq msb");

      // Mid-window reset: the partial ADD must never produce a result.
      drive(6'b000101, 32'd1234, 32'd4321, 10);
      reset = 1'b1;
      @(negedge clk);
      check("midreset cycle", {24'd0, cycle}, 32'd0);
      check("midreset o_valid", {31'd0, o_valid}, 32'd0);
      check("midreset result", result, 32'd0);
      check("midreset result_valid", {31'd0, result_valid}, 32'd0);
      inst = 6'd0;
      A = 1'b0;
      B = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      issue(6'b000101, 32'd1000, 32'd24, 32'd1024, 1'b0, 1'b0, "add after reset");

      foreach (ops[o])
         foreach (vals[j])
            foreach (vals[k])
               issue_model(ops[o], vals[j], vals[k]);

      inst = 6'd0;
      A = 1'b0;
      B = 1'b0;
      repeat (40) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
